// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : parity_stream_checker
//  Description : Single-entry registered parity checker for a valid/ready
//                word stream. Each accepted word is checked against its
//                parity bit under even/odd mode and forwarded one cycle later.
//                Also keeps a saturating error counter and a sticky error flag.
//                Optional build macro PARITY_CHK_DROP_EN: erroneous words are
//                counted but not forwarded, and out_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_err_count;
    logic              r_err_sticky;

    logic w_accept;
    logic w_err;
    logic w_err_accept;

    // Slot may take a new word when empty or when its word leaves this cycle.
    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    // Flags when the ones-count of {data, parity} disagrees with the mode.
    assign w_err        = (^in_data) ^ in_parity ^ mode;
    assign w_err_accept = w_accept && w_err;

`ifdef PARITY_CHK_DROP_EN
    // Erroneous words never reach the output slot, so data only loads on clean words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= !w_err;
            if (!w_err) begin
                r_out_data <= in_data;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_err = 1'b0;
`else
    logic r_out_err;

    // Output slot: load on accept, empty when popped with nothing new arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_err = r_out_err;
`endif

    // Error status: clear wins over history, but a concurrent error still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_err_sticky <= 1'b0;
        end else if (clr) begin
            r_err_count  <= w_err_accept ? c_CNT_ONE : '0;
            r_err_sticky <= w_err_accept;
        end else if (w_err_accept) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != c_CNT_MAX) begin
                r_err_count <= r_err_count + c_CNT_ONE;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign err_count  = r_err_count;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_stream_checker
//  Description : Self-checking bench for parity_stream_checker (CNT_W=2 so
//                counter saturation is reachable). Works in both the default
//                build and with PARITY_CHK_DROP_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parity_stream_checker;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_parity = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;
    logic              err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: one-deep queue + counters -------------
    logic [DATA_W:0] m_q[$];        // {err, data}
    logic [DATA_W-1:0] m_last_data;
    logic              m_last_err;
    int                m_cnt;
    logic              m_sticky;
    logic              m_ready_exp;
    logic              m_ready_obs;

    function automatic logic parity_err(input logic [DATA_W-1:0] d, input logic p, input logic md);
        int ones;
        ones = $countones(d) + int'(p);
        // even mode: error on odd total; odd mode: error on even total
        return md ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic logic drop_build();
`ifdef PARITY_CHK_DROP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last_data = '0;
        m_last_err  = 1'b0;
        m_cnt       = 0;
        m_sticky    = 1'b0;
    endtask

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic p,
                         input logic md, input logic ordy, input logic c);
        logic acc, e;
        in_valid  = v;
        in_data   = d;
        in_parity = p;
        mode      = md;
        out_ready = ordy;
        clr       = c;
        m_ready_exp = (m_q.size() == 0) || ordy;
        acc = v && m_ready_exp;
        e   = parity_err(d, p, md);
        @(negedge clk);
        m_ready_obs = in_ready;
        @(posedge clk);
        if (ordy && m_q.size() != 0) void'(m_q.pop_front());
        if (acc && !(drop_build() && e)) begin
            m_q.push_back({e, d});
            m_last_data = d;
            m_last_err  = drop_build() ? 1'b0 : e;
        end
        if (c) begin
            m_cnt    = (acc && e) ? 1 : 0;
            m_sticky = acc && e;
        end else if (acc && e) begin
            m_cnt    = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
            m_sticky = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);   // erroneous word, held
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_tests++;
        if (err_count !== '0 || err_sticky !== 1'b0) begin
            n_fail++; $display("FAIL reset_status got cnt=%0d sticky=%b want 0/0", err_count, err_sticky);
        end
        n_tests++;
        if (out_data !== '0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_data got %h/%b want 00/0", out_data, out_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_even();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL even_ok got v=%b d=%h e=%b want 1/01/0", out_valid, out_data, out_err);
        end
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== (m_q.size() != 0) || out_err !== m_last_err || out_data !== m_last_data) begin
            n_fail++; $display("FAIL even_err got v=%b d=%h e=%b want %b/%h/%b",
                               out_valid, out_data, out_err, m_q.size() != 0, m_last_data, m_last_err);
        end
        n_tests++;
        if (int'(err_count) !== 1 || err_sticky !== 1'b1) begin
            n_fail++; $display("FAIL even_status got cnt=%0d sticky=%b want 1/1", err_count, err_sticky);
        end
    endtask

    task automatic test_odd();
        logic [DATA_W-1:0] dv[4] = '{8'h00, 8'h03, 8'h03, 8'hFF};
        logic              pv[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dv[i], pv[i], 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== (m_q.size() != 0) || out_err !== m_last_err || out_data !== m_last_data) begin
                n_fail++; $display("FAIL odd_word%0d got v=%b d=%h e=%b want %b/%h/%b", i,
                                   out_valid, out_data, out_err, m_q.size() != 0, m_last_data, m_last_err);
            end
        end
        n_tests++;
        if (int'(err_count) !== 1) begin n_fail++; $display("FAIL odd_count got %0d want 1", err_count); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (m_ready_obs !== 1'b0 || out_data !== 8'hA5 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h want 0/1/a5", i, m_ready_obs, out_valid, out_data);
            end
        end
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (m_ready_obs !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_fail++; $display("FAIL bp_release got rdy=%b v=%b d=%h want 1/1/5a", m_ready_obs, out_valid, out_data);
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A) begin
            n_fail++; $display("FAIL bp_drain got v=%b d=%h want 0/5a", out_valid, out_data);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (int'(err_count) !== 3) begin n_fail++; $display("FAIL sat_count got %0d want 3", err_count); end
        drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (int'(err_count) !== 1 || err_sticky !== 1'b1) begin
            n_fail++; $display("FAIL clr_with_err got cnt=%0d sticky=%b want 1/1", err_count, err_sticky);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (err_count !== '0 || err_sticky !== 1'b0) begin
            n_fail++; $display("FAIL clr_alone got cnt=%0d sticky=%b want 0/0", err_count, err_sticky);
        end
    endtask

    task automatic test_drop();
        logic [DATA_W-1:0] dv[3] = '{8'h01, 8'h01, 8'h02};
        logic              pv[3] = '{1'b1, 1'b0, 1'b1};
        logic [DATA_W-1:0] seen[$];
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, dv[i], pv[i], 1'b0, 1'b1, 1'b0);
            if (out_valid === 1'b1) seen.push_back(out_data);
        end
        n_tests++;
        if (drop_build()) begin
            if (seen.size() != 2 || seen[0] !== 8'h01 || seen[1] !== 8'h02) begin
                n_fail++; $display("FAIL drop_stream got %0d words want 01,02", seen.size());
            end
        end else if (seen.size() != 3) begin
            n_fail++; $display("FAIL fwd_stream got %0d words want 3", seen.size());
        end
        n_tests++;
        if (int'(err_count) !== 1) begin n_fail++; $display("FAIL drop_count got %0d want 1", err_count); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            n_tests++;
            if (m_ready_obs !== m_ready_exp || out_valid !== (m_q.size() != 0) ||
                out_data !== m_last_data || out_err !== m_last_err ||
                int'(err_count) !== m_cnt || err_sticky !== m_sticky) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d] got rdy=%b v=%b d=%h e=%b c=%0d s=%b want %b/%b/%h/%b/%0d/%b",
                             i, m_ready_obs, out_valid, out_data, out_err, err_count, err_sticky,
                             m_ready_exp, m_q.size() != 0, m_last_data, m_last_err, m_cnt, m_sticky);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_even();
        test_odd();
        test_back_to_back();
        test_saturation();
        test_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
